game_mode_ctrl: RTL and testbench

GAME_MODE_CTRL -- requirements
Module: game_mode_ctrl

---
 rtl/game_mode_pkg.sv | 43 ++++
 rtl/ps2_key_event.sv | 57 +++++
 rtl/game_mode_ctrl.sv | 176 +++++++++++++++++
 tb/tb_game_mode_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_mode_pkg.sv
// Shared definitions for the game mode controller: mode codes, default
// PS/2 make codes, the protocol prefix bytes and the mode-to-display mapping.
package game_mode_pkg;

    localparam int unsigned MODE_W  = 3;
    localparam int unsigned KEY_W   = 8;
    localparam int unsigned HEX_W   = 4;
    localparam int unsigned TIMER_W = 32;

    typedef enum logic [MODE_W-1:0] {
        MODE_MENU    = 3'd0,
        MODE_INGAME  = 3'd1,
        MODE_PAUSED  = 3'd2,
        MODE_ENDGAME = 3'd3,
        MODE_BOARD   = 3'd4
    } mode_e;

    // Default make codes (Enter, P, Esc, L)
    localparam logic [KEY_W-1:0] KEY_START_DEF = 8'h5A;
    localparam logic [KEY_W-1:0] KEY_PAUSE_DEF = 8'h4D;
    localparam logic [KEY_W-1:0] KEY_QUIT_DEF  = 8'h76;
    localparam logic [KEY_W-1:0] KEY_BOARD_DEF = 8'h4B;

    // PS/2 protocol bytes: break prefix and extended-key prefix
    localparam logic [KEY_W-1:0] KEY_BREAK = 8'hF0;
    localparam logic [KEY_W-1:0] KEY_EXT   = 8'hE0;

    // Display code differs from the mode encoding (PAUSED/ENDGAME swapped)
    function automatic logic [HEX_W-1:0] mode_hex(input mode_e m);
        logic [HEX_W-1:0] h;
        h = 4'd0;
        case (m)
            MODE_MENU:    h = 4'd0;
            MODE_INGAME:  h = 4'd1;
            MODE_ENDGAME: h = 4'd2;
            MODE_PAUSED:  h = 4'd3;
            MODE_BOARD:   h = 4'd4;
            default:      h = 4'd0;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/ps2_key_event.sv
// Turns raw strobed PS/2 bytes into make-code events. A break prefix (F0)
// arms a flag that swallows the following byte; an extended prefix (E0)
// is ignored and leaves the flag as it was.
// Ports:
//   clk, resetn        clock, async active-low reset
//   clr                synchronous clear of the pending-break flag
//   key_data           received byte
//   key_pressed        one-cycle strobe qualifying key_data
//   key_evt            combinational: a make code is present this cycle
//   key_code           combinational: the byte accompanying key_evt
module ps2_key_event
    import game_mode_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic [KEY_W-1:0] key_data,
    input  logic             key_pressed,
    output logic             key_evt,
    output logic [KEY_W-1:0] key_code
);

    logic r_break_pend;
    logic w_break_pend_nxt;
    logic w_is_break;
    logic w_is_ext;

    assign w_is_break = (key_data == KEY_BREAK);
    assign w_is_ext   = (key_data == KEY_EXT);

    // Combinational so the controller can react on the same edge as the strobe
    assign key_evt  = key_pressed && !w_is_break && !w_is_ext && !r_break_pend;
    assign key_code = key_data;

    // Break flag: set by F0, held across E0, cleared by any other strobed byte
    always_comb begin
        w_break_pend_nxt = r_break_pend;
        if (clr) begin
            w_break_pend_nxt = 1'b0;
        end else if (key_pressed) begin
            if (w_is_break) begin
                w_break_pend_nxt = 1'b1;
            end else if (!w_is_ext) begin
                w_break_pend_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_break_pend <= 1'b0;
        end else begin
            r_break_pend <= w_break_pend_nxt;
        end
    end

endmodule

// File: rtl/game_mode_ctrl.sv
// Top-level game mode controller: MENU / INGAME / PAUSED / ENDGAME /
// LEADERBOARD state machine driven by PS/2 key events, the round-finished
// level and a soft quit, with auto-advance timers and a round counter.
// Ports:
//   clk, resetn        clock, async active-low reset
//   user_quit          synchronous soft quit to MENU
//   game_over          round finished (level)
//   ps2_key_data       received PS/2 byte
//   ps2_key_pressed    strobe qualifying ps2_key_data
//   mode               current mode code
//   ingame_on          high in INGAME, PAUSED, ENDGAME
//   game_run           high only in INGAME
//   hex0               display code for the current mode
//   round_start        one-cycle pulse on MENU->INGAME
//   round_count        saturating count of rounds started
module game_mode_ctrl
    import game_mode_pkg::*;
#(
    parameter logic [KEY_W-1:0]   START_KEY     = KEY_START_DEF,
    parameter logic [KEY_W-1:0]   PAUSE_KEY     = KEY_PAUSE_DEF,
    parameter logic [KEY_W-1:0]   QUIT_KEY      = KEY_QUIT_DEF,
    parameter logic [KEY_W-1:0]   BOARD_KEY     = KEY_BOARD_DEF,
    parameter logic [TIMER_W-1:0] END_TIMEOUT   = 32'd250_000_000,
    parameter logic [TIMER_W-1:0] BOARD_TIMEOUT = 32'd500_000_000,
    parameter int unsigned        ROUND_W       = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               user_quit,
    input  logic               game_over,
    input  logic [KEY_W-1:0]   ps2_key_data,
    input  logic               ps2_key_pressed,
    output logic [MODE_W-1:0]  mode,
    output logic               ingame_on,
    output logic               game_run,
    output logic [HEX_W-1:0]   hex0,
    output logic               round_start,
    output logic [ROUND_W-1:0] round_count
);

    localparam logic [TIMER_W-1:0] END_LAST   = END_TIMEOUT - 32'd1;
    localparam logic [TIMER_W-1:0] BOARD_LAST = BOARD_TIMEOUT - 32'd1;
    localparam logic [TIMER_W-1:0] TIMER_MAX  = '1;
    localparam logic [ROUND_W-1:0] ROUND_MAX  = '1;

    mode_e              r_mode;
    mode_e              w_mode_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               r_ingame_on;
    logic               r_game_run;
    logic [HEX_W-1:0]   r_hex0;
    logic               r_round_start;
    logic [ROUND_W-1:0] r_round_count;
    logic [ROUND_W-1:0] w_round_count_nxt;
    logic               w_round_start;

    logic               w_key_evt;
    logic [KEY_W-1:0]   w_key_code;
    logic               w_key_start;
    logic               w_key_pause;
    logic               w_key_quit;
    logic               w_key_board;
    logic               w_end_expire;
    logic               w_board_expire;

    // Make-code extraction (break codes and E0 prefixes filtered out)
    ps2_key_event u_key_event (
        .clk         (clk),
        .resetn      (resetn),
        .clr         (user_quit),
        .key_data    (ps2_key_data),
        .key_pressed (ps2_key_pressed),
        .key_evt     (w_key_evt),
        .key_code    (w_key_code)
    );

    assign w_key_start = w_key_evt && (w_key_code == START_KEY);
    assign w_key_pause = w_key_evt && (w_key_code == PAUSE_KEY);
    assign w_key_quit  = w_key_evt && (w_key_code == QUIT_KEY);
    assign w_key_board = w_key_evt && (w_key_code == BOARD_KEY);

    // A zero timeout parameter disables the corresponding auto-advance
    assign w_end_expire   = (END_TIMEOUT != 32'd0)   && (r_timer == END_LAST);
    assign w_board_expire = (BOARD_TIMEOUT != 32'd0) && (r_timer == BOARD_LAST);

    // Next-mode decode; soft quit overrides every other transition
    always_comb begin
        w_mode_nxt = r_mode;
        case (r_mode)
            MODE_MENU: begin
                if (w_key_start) begin
                    w_mode_nxt = MODE_INGAME;
                end else if (w_key_board) begin
                    w_mode_nxt = MODE_BOARD;
                end
            end
            MODE_INGAME: begin
                if (game_over) begin
                    w_mode_nxt = MODE_ENDGAME;
                end else if (w_key_pause) begin
                    w_mode_nxt = MODE_PAUSED;
                end else if (w_key_quit) begin
                    w_mode_nxt = MODE_MENU;
                end
            end
            MODE_PAUSED: begin
                if (w_key_pause) begin
                    w_mode_nxt = MODE_INGAME;
                end else if (w_key_quit) begin
                    w_mode_nxt = MODE_MENU;
                end
            end
            MODE_ENDGAME: begin
                if (w_key_start || w_key_quit) begin
                    w_mode_nxt = MODE_MENU;
                end else if (w_end_expire) begin
                    w_mode_nxt = MODE_BOARD;
                end
            end
            MODE_BOARD: begin
                if (w_key_start || w_key_quit || w_board_expire) begin
                    w_mode_nxt = MODE_MENU;
                end
            end
            default: w_mode_nxt = MODE_MENU;
        endcase
        if (user_quit) begin
            w_mode_nxt = MODE_MENU;
        end
    end

    // Timeout counter: zero on any mode change, saturating count in timed modes
    always_comb begin
        w_timer_nxt = '0;
        if (!user_quit && (w_mode_nxt == r_mode) &&
            ((r_mode == MODE_ENDGAME) || (r_mode == MODE_BOARD))) begin
            w_timer_nxt = (r_timer == TIMER_MAX) ? r_timer : r_timer + 32'd1;
        end
    end

    assign w_round_start     = (r_mode == MODE_MENU) && (w_mode_nxt == MODE_INGAME);
    assign w_round_count_nxt = (w_round_start && (r_round_count != ROUND_MAX)) ?
                               r_round_count + ROUND_W'(1) : r_round_count;

    // Outputs are decoded from the next mode so they align with r_mode
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mode        <= MODE_MENU;
            r_timer       <= '0;
            r_ingame_on   <= 1'b0;
            r_game_run    <= 1'b0;
            r_hex0        <= '0;
            r_round_start <= 1'b0;
            r_round_count <= '0;
        end else begin
            r_mode        <= w_mode_nxt;
            r_timer       <= w_timer_nxt;
            r_ingame_on   <= (w_mode_nxt == MODE_INGAME) ||
                             (w_mode_nxt == MODE_PAUSED) ||
                             (w_mode_nxt == MODE_ENDGAME);
            r_game_run    <= (w_mode_nxt == MODE_INGAME);
            r_hex0        <= mode_hex(w_mode_nxt);
            r_round_start <= w_round_start;
            r_round_count <= w_round_count_nxt;
        end
    end

    assign mode        = r_mode;
    assign ingame_on   = r_ingame_on;
    assign game_run    = r_game_run;
    assign hex0        = r_hex0;
    assign round_start = r_round_start;
    assign round_count = r_round_count;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Directed testbench for game_mode_ctrl with short timeouts and a 2-bit
// round counter so timer expiry and saturation are reachable quickly.
module tb_game_mode_ctrl;

    logic       clk;
    logic       resetn;
    logic       user_quit;
    logic       game_over;
    logic [7:0] ps2_key_data;
    logic       ps2_key_pressed;
    logic [2:0] mode;
    logic       ingame_on;
    logic       game_run;
    logic [3:0] hex0;
    logic       round_start;
    logic [1:0] round_count;

    int n_tests = 0;
    int n_fail  = 0;

    game_mode_ctrl #(
        .END_TIMEOUT   (32'd10),
        .BOARD_TIMEOUT (32'd5),
        .ROUND_W       (2)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .user_quit       (user_quit),
        .game_over       (game_over),
        .ps2_key_data    (ps2_key_data),
        .ps2_key_pressed (ps2_key_pressed),
        .mode            (mode),
        .ingame_on       (ingame_on),
        .game_run        (game_run),
        .hex0            (hex0),
        .round_start     (round_start),
        .round_count     (round_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One strobed byte; returns at the negedge after the capturing posedge
    task automatic key(input logic [7:0] k);
        @(negedge clk);
        ps2_key_data    = k;
        ps2_key_pressed = 1'b1;
        @(negedge clk);
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    task automatic pulse_quit();
        @(negedge clk);
        user_quit = 1'b1;
        @(negedge clk);
        user_quit = 1'b0;
    endtask

    task automatic pulse_game_over();
        @(negedge clk);
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
    endtask

    initial begin
        resetn          = 1'b0;
        user_quit       = 1'b0;
        game_over       = 1'b0;
        ps2_key_data    = 8'h00;
        ps2_key_pressed = 1'b0;
        idle(3);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_hex0", 32'(hex0), 32'd0);
        check("rst_ingame_on", 32'(ingame_on), 32'd0);
        check("rst_game_run", 32'(game_run), 32'd0);
        check("rst_round_start", 32'(round_start), 32'd0);
        check("rst_round_count", 32'(round_count), 32'd0);
        resetn = 1'b1;
        idle(1);

        // Start a round from MENU
        key(8'h5A);
        check("start_mode", 32'(mode), 32'd1);
        check("start_pulse", 32'(round_start), 32'd1);
        check("start_count", 32'(round_count), 32'd1);
        check("start_hex0", 32'(hex0), 32'd1);
        check("start_game_run", 32'(game_run), 32'd1);
        check("start_ingame_on", 32'(ingame_on), 32'd1);
        idle(1);
        check("start_pulse_end", 32'(round_start), 32'd0);

        // Break code swallows the next byte
        key(8'hF0);
        key(8'h5A);
        check("break_no_evt_mode", 32'(mode), 32'd1);
        check("break_no_evt_count", 32'(round_count), 32'd1);

        // Pause toggle
        key(8'h4D);
        check("pause_mode", 32'(mode), 32'd2);
        check("pause_hex0", 32'(hex0), 32'd3);
        check("pause_game_run", 32'(game_run), 32'd0);
        check("pause_ingame_on", 32'(ingame_on), 32'd1);
        key(8'h4D);
        check("unpause_mode", 32'(mode), 32'd1);
        check("unpause_game_run", 32'(game_run), 32'd1);

        // E0 alone is ignored; following make code still acts
        key(8'hE0);
        key(8'h4D);
        check("ext_then_pause", 32'(mode), 32'd2);
        key(8'h4D);
        check("ext_unpause", 32'(mode), 32'd1);

        // E0 between F0 and the released code keeps break pending
        key(8'hF0);
        key(8'hE0);
        key(8'h4D);
        check("break_ext_no_evt", 32'(mode), 32'd1);

        // game_over beats PAUSE_KEY in the same cycle
        @(negedge clk);
        game_over       = 1'b1;
        ps2_key_data    = 8'h4D;
        ps2_key_pressed = 1'b1;
        @(negedge clk);
        game_over       = 1'b0;
        ps2_key_pressed = 1'b0;
        check("over_mode", 32'(mode), 32'd3);
        check("over_hex0", 32'(hex0), 32'd2);
        check("over_ingame_on", 32'(ingame_on), 32'd1);
        check("over_game_run", 32'(game_run), 32'd0);

        // ENDGAME lasts 10 cycles, LEADERBOARD 5 cycles
        idle(9);
        check("end_hold", 32'(mode), 32'd3);
        idle(1);
        check("end_to_board", 32'(mode), 32'd4);
        check("board_hex0", 32'(hex0), 32'd4);
        check("board_ingame_on", 32'(ingame_on), 32'd0);
        idle(4);
        check("board_hold", 32'(mode), 32'd4);
        idle(1);
        check("board_to_menu", 32'(mode), 32'd0);
        check("menu_hex0", 32'(hex0), 32'd0);

        // Round counter saturates at 3
        key(8'h5A);
        check("r2_count", 32'(round_count), 32'd2);
        key(8'h76);
        check("r2_quit", 32'(mode), 32'd0);
        key(8'h5A);
        check("r3_count", 32'(round_count), 32'd3);
        key(8'h76);
        key(8'h5A);
        check("r4_sat_count", 32'(round_count), 32'd3);
        check("r4_pulse", 32'(round_start), 32'd1);

        // PAUSED ignores game_over; user_quit forces MENU
        key(8'h4D);
        check("p_mode", 32'(mode), 32'd2);
        pulse_game_over();
        check("p_ignore_over", 32'(mode), 32'd2);
        pulse_quit();
        check("uq_mode", 32'(mode), 32'd0);
        check("uq_count", 32'(round_count), 32'd3);
        check("uq_ingame_on", 32'(ingame_on), 32'd0);

        // Leaderboard from menu, start key returns without a round
        key(8'h4B);
        check("lb_mode", 32'(mode), 32'd4);
        key(8'h5A);
        check("lb_exit_mode", 32'(mode), 32'd0);
        check("lb_exit_pulse", 32'(round_start), 32'd0);

        // user_quit clears a pending break
        key(8'hF0);
        pulse_quit();
        key(8'h5A);
        check("uq_clr_break", 32'(mode), 32'd1);

        // ENDGAME key exit beats timer
        pulse_game_over();
        check("eg2_mode", 32'(mode), 32'd3);
        key(8'h76);
        check("eg2_quit", 32'(mode), 32'd0);

        // Async reset mid-ENDGAME
        key(8'h5A);
        pulse_game_over();
        idle(3);
        check("pre_rst_mode", 32'(mode), 32'd3);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_mode", 32'(mode), 32'd0);
        check("arst_hex0", 32'(hex0), 32'd0);
        check("arst_ingame_on", 32'(ingame_on), 32'd0);
        check("arst_game_run", 32'(game_run), 32'd0);
        check("arst_round_start", 32'(round_start), 32'd0);
        check("arst_count", 32'(round_count), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(12);
        check("post_rst_no_timeout", 32'(mode), 32'd0);
        key(8'h5A);
        check("post_rst_start", 32'(mode), 32'd1);
        check("post_rst_count", 32'(round_count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
